riscv_irq_arbiter: RTL and testbench

Fixed-priority interrupt arbiter between the raw interrupt lines and the ID-stage controller. It registers the 18 level-triggered lines (software, timer, external, 15 fast) into a pending vector and masks them with the CSR enables. It then selects the highest-priority enabled line, encodes it as a 5-bit cause ID and presents a held request to the controller under a request/ack/kill handshake. It also exports the registered pending vector for the `mip` CSR and a wake-up flag for WFI.

---
 rtl/riscv_irq_arbiter.sv | 126 ++++++++++++
 tb/tb_riscv_irq_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/riscv_irq_arbiter.sv
// Purpose : fixed-priority interrupt arbiter feeding a held cause ID to the ID-stage controller.
// Latency : 2 clk edges from an irq line rising to irq_req_o (line sample, then arbitration).
// Backpressure: request and cause ID are held until ctrl_ack_i or ctrl_kill_i; no re-arbitration meanwhile.
//
// Ports:
//   clk, rst            core clock, synchronous active-high reset
//   irq_software_i      machine software interrupt (level)
//   irq_timer_i         machine timer interrupt (level)
//   irq_external_i      machine external interrupt (level)
//   irq_fast_i[14:0]    fast interrupts (level)
//   mie_i[17:0]         enables {software, timer, external, fast[14:0]}
//   m_IE_i              global machine interrupt enable
//   ctrl_ack_i          controller accepted the presented interrupt
//   ctrl_kill_i         controller withdrew the presented interrupt
//   irq_req_o           interrupt request to the controller
//   irq_id_o[4:0]       cause ID of the presented interrupt
//   mip_o[17:0]         registered pending lines, same order as mie_i
//   irq_wakeup_o        any pending & enabled line, ignores m_IE_i (WFI wake-up)
module riscv_irq_arbiter #(
    parameter bit FAST_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        irq_software_i,
    input  logic        irq_timer_i,
    input  logic        irq_external_i,
    input  logic [14:0] irq_fast_i,
    input  logic [17:0] mie_i,
    input  logic        m_IE_i,
    input  logic        ctrl_ack_i,
    input  logic        ctrl_kill_i,
    output logic        irq_req_o,
    output logic [4:0]  irq_id_o,
    output logic [17:0] mip_o,
    output logic        irq_wakeup_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        DONE    = 2'd2
    } exc_state_t;

    exc_state_t  exc_cs;
    logic [17:0] pending_q;
    logic [4:0]  id_q;

    logic [17:0] masked;
    logic        fast_any;
    logic        std_any;
    logic [4:0]  fast_id;
    logic [4:0]  std_id;
    logic [4:0]  win_id;

    assign masked   = pending_q & mie_i;
    assign fast_any = |masked[14:0];
    assign std_any  = |masked[17:15];

    // Ascending scan so the highest-numbered fast line is the one left standing.
    always_comb begin
        fast_id = 5'd0;
        for (int k = 0; k < 15; k++) begin
            if (masked[k]) begin
                fast_id = 5'd16 + 5'(k);
            end
        end
    end

    // Standard group: external > software > timer.
    always_comb begin
        std_id = 5'd0;
        if (masked[15]) begin
            std_id = 5'd11;
        end else if (masked[17]) begin
            std_id = 5'd3;
        end else if (masked[16]) begin
            std_id = 5'd7;
        end
    end

    always_comb begin
        if (FAST_FIRST) begin
            win_id = fast_any ? fast_id : std_id;
        end else begin
            win_id = std_any ? std_id : fast_id;
        end
    end

    // Lines are sampled straight through every cycle; nothing is latched here,
    // so a source dropping its line clears mip on the next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
            exc_cs    <= IDLE;
            id_q      <= '0;
        end else begin
            pending_q <= {irq_software_i, irq_timer_i, irq_external_i, irq_fast_i};
            case (exc_cs)
                IDLE: begin
                    if (m_IE_i && (|masked)) begin
                        id_q   <= win_id;
                        exc_cs <= PENDING;
                    end
                end
                PENDING: begin
                    // id_q frozen here; ack takes precedence over kill.
                    if (ctrl_ack_i) begin
                        exc_cs <= DONE;
                    end else if (ctrl_kill_i) begin
                        exc_cs <= IDLE;
                    end
                end
                // One quiet cycle so the controller can update mstatus/mie
                // before the next arbitration.
                DONE:    exc_cs <= IDLE;
                default: exc_cs <= IDLE;
            endcase
        end
    end

    assign irq_req_o    = (exc_cs == PENDING);
    assign irq_id_o     = id_q;
    assign mip_o        = pending_q;
    assign irq_wakeup_o = |masked;

endmodule

// File: tb/tb_riscv_irq_arbiter.sv
module tb_riscv_irq_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        irq_software_i;
    logic        irq_timer_i;
    logic        irq_external_i;
    logic [14:0] irq_fast_i;
    logic [17:0] mie_i;
    logic        m_IE_i;
    logic        ctrl_ack_i;
    logic        ctrl_kill_i;

    logic        req1, wake1, req0, wake0;
    logic [4:0]  id1, id0;
    logic [17:0] mip1, mip0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    riscv_irq_arbiter #(.FAST_FIRST(1'b1)) dut_ff1 (
        .clk(clk), .rst(rst),
        .irq_software_i(irq_software_i), .irq_timer_i(irq_timer_i),
        .irq_external_i(irq_external_i), .irq_fast_i(irq_fast_i),
        .mie_i(mie_i), .m_IE_i(m_IE_i),
        .ctrl_ack_i(ctrl_ack_i), .ctrl_kill_i(ctrl_kill_i),
        .irq_req_o(req1), .irq_id_o(id1), .mip_o(mip1), .irq_wakeup_o(wake1)
    );

    riscv_irq_arbiter #(.FAST_FIRST(1'b0)) dut_ff0 (
        .clk(clk), .rst(rst),
        .irq_software_i(irq_software_i), .irq_timer_i(irq_timer_i),
        .irq_external_i(irq_external_i), .irq_fast_i(irq_fast_i),
        .mie_i(mie_i), .m_IE_i(m_IE_i),
        .ctrl_ack_i(ctrl_ack_i), .ctrl_kill_i(ctrl_kill_i),
        .irq_req_o(req0), .irq_id_o(id0), .mip_o(mip0), .irq_wakeup_o(wake0)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Advance one rising edge; inputs are driven and outputs sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lines(input logic sw, input logic tm, input logic ex, input logic [14:0] fa);
        irq_software_i = sw;
        irq_timer_i    = tm;
        irq_external_i = ex;
        irq_fast_i     = fa;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        set_lines(1'b1, 1'b1, 1'b1, 15'h7FFF);
        mie_i       = 18'h3FFFF;
        m_IE_i      = 1'b1;
        ctrl_ack_i  = 1'b0;
        ctrl_kill_i = 1'b0;

        // Reset held for 3 cycles with everything asserted.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_req", req1, 0);
            chk("rst_id", id1, 0);
            chk("rst_mip", mip1, 0);
            chk("rst_wake", wake1, 0);
        end
        rst = 1'b0;
        tick();
        chk("rel_req_e1", req1, 0);
        chk("rel_mip_e1", mip1, 18'h3FFFF);
        tick();
        chk("rel_req_e2", req1, 1);
        chk("rel_id_e2", id1, 30);

        // Priority: timer, external, fast[2].
        set_lines(1'b0, 1'b0, 1'b0, 15'h0000);
        do_reset();
        set_lines(1'b0, 1'b1, 1'b1, 15'h0004);
        tick(); tick();
        chk("pri_fast2_req", req1, 1);
        chk("pri_fast2_id", id1, 18);
        chk("pri_ff0_ext_id", id0, 11);

        // fast[2] enable cleared.
        set_lines(1'b0, 1'b0, 1'b0, 15'h0000);
        do_reset();
        mie_i = 18'h3FFFB;
        set_lines(1'b0, 1'b1, 1'b1, 15'h0004);
        tick(); tick();
        chk("pri_mask_id", id1, 11);
        mie_i = 18'h3FFFF;

        // Software and timer only.
        set_lines(1'b0, 1'b0, 1'b0, 15'h0000);
        do_reset();
        set_lines(1'b1, 1'b1, 1'b0, 15'h0000);
        tick(); tick();
        chk("pri_sw_id", id1, 3);

        // External and fast[14]: group order decides.
        set_lines(1'b0, 1'b0, 1'b0, 15'h0000);
        do_reset();
        set_lines(1'b0, 1'b0, 1'b1, 15'h4000);
        tick(); tick();
        chk("ff0_ext_id", id0, 11);
        chk("ff1_f14_id", id1, 30);

        // Handshake: timer, ack on first request cycle.
        set_lines(1'b0, 1'b0, 1'b0, 15'h0000);
        do_reset();
        set_lines(1'b0, 1'b1, 1'b0, 15'h0000);
        tick(); tick();
        chk("hs_req", req1, 1);
        chk("hs_id", id1, 7);
        ctrl_ack_i = 1'b1;
        tick();
        ctrl_ack_i = 1'b0;
        chk("hs_done_req", req1, 0);
        tick();
        chk("hs_idle_req", req1, 0);
        tick();
        chk("hs_rereq", req1, 1);
        chk("hs_rereq_id", id1, 7);

        // ack and kill together: DONE path (two quiet cycles).
        ctrl_ack_i  = 1'b1;
        ctrl_kill_i = 1'b1;
        tick();
        ctrl_ack_i  = 1'b0;
        ctrl_kill_i = 1'b0;
        chk("ak_req_e1", req1, 0);
        tick();
        chk("ak_req_e2", req1, 0);
        tick();
        chk("ak_req_e3", req1, 1);

        // kill alone: IDLE then re-request one edge later.
        ctrl_kill_i = 1'b1;
        tick();
        ctrl_kill_i = 1'b0;
        chk("kill_req_e1", req1, 0);
        tick();
        chk("kill_req_e2", req1, 1);
        chk("kill_id_e2", id1, 7);

        // Freeze: higher line arrives, winner drops.
        set_lines(1'b0, 1'b0, 1'b0, 15'h0001);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("frz_req", req1, 1);
            chk("frz_id", id1, 7);
        end
        ctrl_kill_i = 1'b1;
        tick();
        ctrl_kill_i = 1'b0;
        chk("frz_kill_req", req1, 0);
        tick();
        chk("frz_next_req", req1, 1);
        chk("frz_next_id", id1, 16);

        // Gating by m_IE_i.
        set_lines(1'b0, 1'b0, 1'b0, 15'h0000);
        do_reset();
        m_IE_i = 1'b0;
        set_lines(1'b0, 1'b0, 1'b1, 15'h0000);
        tick(); tick(); tick();
        chk("gate_req", req1, 0);
        chk("gate_wake", wake1, 1);
        chk("gate_mip", mip1, 18'h08000);
        mie_i = 18'h00000;
        tick();
        chk("gate_mie0_wake", wake1, 0);
        chk("gate_mie0_req", req1, 0);

        // m_IE_i dropping in PENDING does not retract.
        mie_i  = 18'h3FFFF;
        m_IE_i = 1'b1;
        tick();
        chk("mie_pend_req", req1, 1);
        chk("mie_pend_id", id1, 11);
        m_IE_i = 1'b0;
        tick();
        chk("mie_drop_req", req1, 1);

        // Reset mid-PENDING.
        rst = 1'b1;
        tick();
        chk("rst_pend_req", req1, 0);
        chk("rst_pend_id", id1, 0);
        chk("rst_pend_mip", mip1, 0);
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
